// File: rtl/cipher_uart_pkg.sv
// -----------------------------------------------------------------------------
// cipher_uart_pkg
// Shared definitions for the cipher UART transmitter:
//   tx_state_t            - transmitter FSM state encoding
//   DATA_BITS             - payload bits per UART frame (8N1)
//   DEFAULT_CLKS_PER_BIT  - 50 MHz clock / 115200 baud
// -----------------------------------------------------------------------------
package cipher_uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO with first-word-fall-through head.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   - write request/data; ignored while full
//   pop               - read request; ignored while empty
//   pop_data          - current head entry (valid while !empty)
//   full, empty       - occupancy flags from the pointer state only
// -----------------------------------------------------------------------------
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when addresses match.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;
   logic [DEPTH-1:0][WIDTH-1:0] mem_w;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage: one register per entry; contents need no reset since the
   // pointers define validity.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) entry_d = push_data;
      end

      always_ff @(posedge clk) begin
         entry_q <= entry_d;
      end

      assign mem_w[gi] = entry_q;
   end

   assign pop_data = mem_w[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// cipher_uart_tx
// Buffers encrypted bytes from the Caesar encoder and sends them as 8N1 UART
// frames, LSB first, with back-to-back frames when bytes are queued.
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (>= 2)
//   FIFO_DEPTH   - byte entries buffered ahead of the transmitter (pow2, >= 2)
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_char, in_valid   - byte offered by upstream
//   in_ready            - FIFO not full; transfer on in_valid && in_ready
//   tx                  - registered serial line, idle high
//   busy                - frame in progress or bytes still buffered
// -----------------------------------------------------------------------------
module cipher_uart_tx
   import cipher_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_char,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

   tx_state_t              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;

   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [7:0]             fifo_data;
   logic                   baud_done;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (in_char),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign baud_done = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic, baud counter and FIFO pop
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_data;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (baud_done) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) state_d = ST_STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               cnt_d = '0;
               // Chain straight into the next start bit so queued bytes
               // leave with no idle gap.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_data;
                  state_d  = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: line level for the current state, registered into tx_q so
   // the whole waveform is delayed uniformly by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         ST_IDLE:  tx_d = 1'b1;
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[bit_q];
         ST_STOP:  tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx       = tx_q;
   assign in_ready = !fifo_full;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_cipher_uart_tx
// Scoreboarded bench for cipher_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The driver records each accepted byte with its acceptance edge; a line
// monitor rebuilds frames from tx and compares byte value and start cycle
// against a timing model: start = max(accept + 2, previous start + frame).
// -----------------------------------------------------------------------------
module tb_cipher_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx;
   logic       busy;

   cipher_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_char  (in_char),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // cyc == k between rising edge k and rising edge k+1
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   int   mon_pos    = -1;
   int   last_start = -1000000;
   int   frame_start = 0;
   logic lv[FRAME];

   task automatic decode_frame();
      bit         shape_ok;
      logic [7:0] d;
      exp_t       e;
      int         es;
      shape_ok = 1'b1;
      for (int w = 0; w < 10; w++)
         for (int j = 1; j < CPB; j++)
            if (lv[w*CPB+j] !== lv[w*CPB]) shape_ok = 1'b0;
      if (lv[0] !== 1'b0 || lv[9*CPB] !== 1'b1) shape_ok = 1'b0;
      for (int i = 0; i < 8; i++) d[i] = lv[(i+1)*CPB];
      $display("frame data=0x%02h start=%0d", d, frame_start);
      check("frame_shape", int'(shape_ok), 1);
      check("frame_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         es = e.acc + 2;
         if (last_start + FRAME > es) es = last_start + FRAME;
         check("frame_start", frame_start, es);
         check("frame_data", int'(d), int'(e.data));
      end
      last_start = frame_start;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mon_pos    = -1;
            last_start = -1000000;
         end else if (mon_pos < 0) begin
            if (tx === 1'b0) begin
               frame_start = cyc;
               lv[0]       = tx;
               mon_pos     = 1;
            end
         end else begin
            lv[mon_pos] = tx;
            mon_pos++;
            if (mon_pos == FRAME) begin
               decode_frame();
               mon_pos = -1;
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called right after a falling edge; returns right after the falling edge
   // that follows the transfer edge, leaving in_valid asserted.
   task automatic send(input logic [7:0] b, output int acc);
      int wait_n;
      wait_n   = 0;
      acc      = -1;
      in_char  = b;
      in_valid = 1'b1;
      while (!in_ready && wait_n < 500) begin
         @(negedge clk);
         wait_n++;
      end
      if (!in_ready) begin
         check("accept_timeout", int'(in_ready), 1);
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      sb.push_back('{b, acc});
      $display("push data=0x%02h accept_edge=%0d", b, acc);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((busy || sb.size() != 0 || mon_pos >= 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", int'(n < 5000), 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a6, r0, p0, pd;
      logic [7:0] rb;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte into an idle block
      send(8'h44, a);
      wait_drain();
      check("idle_tx", int'(tx), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_ready", int'(in_ready), 1);

      // Three consecutive bytes: contiguous frames
      send(8'h4B, a);
      send(8'h48, a);
      send(8'h4F, a);
      wait_drain();

      // Six bytes with in_valid held: FIFO fills, sixth waits for first pop
      send(8'h31, a1);
      for (int k = 0; k < 4; k++) send(8'h32 + 8'(k), a);
      check("ready_low_when_full", int'(in_ready), 0);
      send(8'h36, a6);
      check("sixth_accept_edge", a6, a1 + FRAME + 2);
      wait_drain();

      // Reset during DATA bit 3 with two bytes buffered
      send(8'hA5, r0);
      send(8'h5A, a);
      send(8'hC3, a);
      in_valid = 1'b0;
      while (cyc < r0 + 2 + 4*CPB) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midreset_tx", int'(tx), 1);
      check("midreset_busy", int'(busy), 0);
      check("midreset_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      idle(100);
      check("post_reset_busy", int'(busy), 0);
      check("post_reset_tx", int'(tx), 1);

      // Push on the same edge as the STOP-end pop with two bytes buffered
      send(8'h10, p0);
      send(8'h20, a);
      send(8'h30, a);
      in_valid = 1'b0;
      while (cyc < p0 + FRAME) @(negedge clk);
      send(8'h40, pd);
      check("push_at_pop_edge", pd, p0 + FRAME + 1);
      check("ready_after_pushpop", int'(in_ready), 1);
      send(8'h50, a);
      send(8'h60, a);
      check("full_after_two_more", int'(in_ready), 0);
      wait_drain();

      // Randomized traffic
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 60));
         rb = 8'($urandom);
         send(rb, a);
      end
      wait_drain();
      check("final_busy", int'(busy), 0);
      check("final_tx", int'(tx), 1);
      check("final_ready", int'(in_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cipher_uart_tx.md
CIPHER_UART_TX -- requirements
Module: cipher_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries buffered ahead of the transmitter; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_char  input  8  encrypted ASCII byte from the Caesar encoder stage.
REQ-006 in_valid  input  1  in_char holds a byte to transfer.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 tx  output  1  serial line, 8N1, idle high; registered output.
REQ-009 busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-010 Transfer occurs on a rising edge where in_valid && in_ready; in_char is written to the FIFO tail.
REQ-011 in_ready = !fifo_full, combinational from FIFO state only, independent of in_valid and of a same-cycle pop; a full FIFO accepts nothing even while popping.
REQ-012 Upstream holding in_valid while in_ready is low loses no byte; each byte transfers exactly once.
REQ-013 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; on the edge where FIFO is non-empty, pop the head into the shift register, go to START.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-016 DATA: tx = shift_reg[bit index], LSB first, each bit CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; at its last cycle, if FIFO non-empty pop and go directly to START (no idle gap), else go to IDLE.
REQ-018 Frame length exactly 10*CLKS_PER_BIT cycles; back-to-back frames contiguous.
REQ-019 Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE -> tx low from edge N+2.
REQ-020 Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit index 3 bits; FIFO pointers $clog2(FIFO_DEPTH)+1 bits, full/empty by MSB compare.
REQ-021 Push and pop in the same cycle (FIFO not full, not empty) both occur; occupancy unchanged.
REQ-022 busy = (state != IDLE) || !fifo_empty.
REQ-023 in_char is not interpreted; all 256 values transmit unchanged.

Reset
REQ-024 While rst_n=0 at an edge: state=IDLE, tx=1, FIFO emptied, counters cleared, busy=0, in_ready=1 after that edge.
REQ-025 Reset mid-frame abandons the frame; tx returns high on the reset edge; buffered bytes are discarded.

Structure
REQ-026 Shared package cipher_uart_pkg holds the FSM state enum (tx_state_t), DATA_BITS=8, and the default CLKS_PER_BIT constant.
REQ-027 FIFO is a sub-module byte_fifo (parameters WIDTH, DEPTH; push/pop/full/empty ports); FSM and baud counter stay in cipher_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte 0x44 ('D', encrypted 'A') into idle block -> tx low from 2 edges after acceptance; per-4-cycle levels 0,0,0,1,0,0,0,1,0,1; then idle high, busy=0.
REQ-029 Bytes 0x4B,0x48,0x4F pushed consecutively -> 120 contiguous frame cycles, no idle high between stop and next start, bytes decoded in order.
REQ-030 in_valid held high with 6 bytes queued during transmission -> 5 accepted (1 in shifter, 4 in FIFO), in_ready low; 6th accepted on the cycle after the first STOP-end pop; all 6 decoded exactly once.
REQ-031 rst_n=0 for 1 cycle at DATA bit 3 with 2 bytes buffered -> tx=1, busy=0, in_ready=1 after the edge; no further frames without new input.
REQ-032 Push at the same edge as a STOP-end pop with FIFO holding 2 -> occupancy stays 2, in_ready stays 1, order preserved.
